router_input_unit: RTL and testbench

- Per-port input stage of the mesh router, directly upstream of the crossbar.
- Buffers incoming flits in a FIFO and computes the partially adaptive (west-first) candidate output ports for each head flit.
- Raises requests to the switch allocator, holds the granted output port for the whole packet (wormhole), and presents granted flits to the crossbar input.

---
 rtl/router_input_unit.sv | 264 ++++++++++++++++++++++++++
 tb/tb_router_input_unit.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/router_input_unit.sv
`default_nettype none
// ============================================================================
// Module      : router_input_unit
// Description : Per-port input stage of a mesh router. Buffers link flits in
//               a small FIFO and computes west-first candidate output ports
//               for each head flit. It raises requests to the switch
//               allocator, holds the granted port for the whole packet
//               (wormhole) and presents granted flits to the crossbar.
// Ports       : clk, rst         - clock, asynchronous active-high reset
//               in_flit/in_valid - link flit input, accepted when in_ready
//               in_ready         - FIFO not full
//               cur_x/cur_y      - this router's mesh coordinates
//               req              - candidate output-port mask to allocator
//               grant            - one-hot allocator grant, same cycle as req
//               out_flit         - FIFO head flit to the crossbar
//               out_valid        - out_flit transfers this cycle
//               out_port         - output port index of the transfer
//               err              - one-cycle protocol error pulse
// Revision    : 1.0 - initial release
// ============================================================================
module router_input_unit #(
    parameter int FLIT_SIZE   = 32,
    parameter int DEPTH       = 4,
    parameter int COORD_WIDTH = 4,
    parameter int NUM_PORTS   = 5
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [FLIT_SIZE-1:0]         in_flit,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [COORD_WIDTH-1:0]       cur_x,
    input  logic [COORD_WIDTH-1:0]       cur_y,
    output logic [NUM_PORTS-1:0]         req,
    input  logic [NUM_PORTS-1:0]         grant,
    output logic [FLIT_SIZE-1:0]         out_flit,
    output logic                         out_valid,
    output logic [$clog2(NUM_PORTS)-1:0] out_port,
    output logic                         err
);

    localparam int c_PTR_W  = $clog2(DEPTH);
    localparam int c_PORT_W = $clog2(NUM_PORTS);

    // Flit type encodings (top two bits of the flit)
    localparam logic [1:0] c_T_BODY   = 2'b00;
    localparam logic [1:0] c_T_HEAD   = 2'b01;
    localparam logic [1:0] c_T_TAIL   = 2'b10;
    localparam logic [1:0] c_T_SINGLE = 2'b11;

    // Port numbering
    localparam int c_P_LOCAL = 0;
    localparam int c_P_NORTH = 1;
    localparam int c_P_EAST  = 2;
    localparam int c_P_SOUTH = 3;
    localparam int c_P_WEST  = 4;

    // FSM states
    localparam logic [0:0] c_S_IDLE   = 1'b0;
    localparam logic [0:0] c_S_ACTIVE = 1'b1;

    localparam logic [c_PTR_W:0]    c_FULL_CNT = (c_PTR_W+1)'(DEPTH);
    localparam logic [c_PTR_W-1:0]  c_PTR_ONE  = c_PTR_W'(1);
    localparam logic [NUM_PORTS-1:0] c_PORT_ONE = NUM_PORTS'(1);

    // ------------------------------------------------------------------
    // FIFO storage
    // ------------------------------------------------------------------
    logic [FLIT_SIZE-1:0] r_mem [DEPTH];
    logic [c_PTR_W-1:0]   r_wr_ptr;
    logic [c_PTR_W-1:0]   r_rd_ptr;
    logic [c_PTR_W:0]     r_count;

    logic w_full;
    logic w_empty;
    logic w_push;
    logic w_pop;

    assign w_full   = (r_count == c_FULL_CNT);
    assign w_empty  = (r_count == '0);
    assign in_ready = !w_full;
    assign w_push   = in_valid && !w_full;

    // Data storage carries no reset; only the pointers define occupancy.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= in_flit;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Head flit decode and west-first route computation
    // ------------------------------------------------------------------
    logic [FLIT_SIZE-1:0]   w_head;
    logic [1:0]             w_type;
    logic                   w_is_hd;
    logic [COORD_WIDTH-1:0] w_dest_x;
    logic [COORD_WIDTH-1:0] w_dest_y;
    logic [NUM_PORTS-1:0]   w_route;

    assign w_head   = r_mem[r_rd_ptr];
    assign out_flit = w_head;
    assign w_type   = w_head[FLIT_SIZE-1 -: 2];
    assign w_is_hd  = (w_type == c_T_HEAD) || (w_type == c_T_SINGLE);
    assign w_dest_y = w_head[COORD_WIDTH-1:0];
    assign w_dest_x = w_head[2*COORD_WIDTH-1:COORD_WIDTH];

    // Any westward hop must be taken first; otherwise every productive
    // direction among East/North/South is offered to the allocator.
    always_comb begin
        w_route = '0;
        if ((w_dest_x == cur_x) && (w_dest_y == cur_y)) begin
            w_route[c_P_LOCAL] = 1'b1;
        end else if (w_dest_x < cur_x) begin
            w_route[c_P_WEST] = 1'b1;
        end else begin
            w_route[c_P_EAST]  = (w_dest_x > cur_x);
            w_route[c_P_NORTH] = (w_dest_y > cur_y);
            w_route[c_P_SOUTH] = (w_dest_y < cur_y);
        end
    end

    // ------------------------------------------------------------------
    // Grant decode
    // ------------------------------------------------------------------
    logic                 w_grant_any;
    logic                 w_grant_onehot;
    logic [c_PORT_W-1:0]  w_grant_idx;

    assign w_grant_any    = (grant != '0);
    assign w_grant_onehot = w_grant_any && ((grant & (grant - c_PORT_ONE)) == '0);

    always_comb begin
        w_grant_idx = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (grant[i]) begin
                w_grant_idx = c_PORT_W'(i);
            end
        end
    end

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    logic [0:0]          r_state;
    logic [0:0]          w_state_nxt;
    logic [c_PORT_W-1:0] r_locked;
    logic                w_lock_ld;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= c_S_IDLE;
            r_locked <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_lock_ld) begin
                r_locked <= w_grant_idx;
            end
        end
    end

    // ------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_S_IDLE: begin
                if (out_valid && (w_type == c_T_HEAD)) begin
                    w_state_nxt = c_S_ACTIVE;
                end
            end
            c_S_ACTIVE: begin
                if (out_valid && (w_type == c_T_TAIL)) begin
                    w_state_nxt = c_S_IDLE;
                end
            end
            default: w_state_nxt = c_S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: output logic
    // A misplaced flit (body/tail in IDLE, head/single in ACTIVE) is popped
    // and discarded with no request, so a drop and a transfer can never
    // coincide and at most one pop happens per cycle.
    // ------------------------------------------------------------------
    logic [NUM_PORTS-1:0] w_lock_mask;
    assign w_lock_mask = c_PORT_ONE << r_locked;

    always_comb begin
        logic v_drop;
        logic v_grant_ok;

        req       = '0;
        v_drop    = 1'b0;
        w_pop     = 1'b0;
        out_valid = 1'b0;
        out_port  = '0;
        err       = 1'b0;
        w_lock_ld = 1'b0;

        if (!w_empty) begin
            if (r_state == c_S_IDLE) begin
                if (w_is_hd) begin
                    req = w_route;
                end else begin
                    v_drop = 1'b1;
                end
            end else begin
                if (w_is_hd) begin
                    v_drop = 1'b1;
                end else begin
                    req = w_lock_mask;
                end
            end
        end

        v_grant_ok = w_grant_onehot && (req != '0) && ((grant & ~req) == '0);

        if (v_drop) begin
            w_pop = 1'b1;
            err   = 1'b1;
        end

        if (w_grant_any) begin
            if (v_grant_ok) begin
                w_pop     = 1'b1;
                out_valid = 1'b1;
                if (r_state == c_S_IDLE) begin
                    out_port  = w_grant_idx;
                    w_lock_ld = 1'b1;
                end else begin
                    out_port = r_locked;
                end
            end else begin
                err = 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_router_input_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_router_input_unit
// Description : Directed self-checking bench for router_input_unit with
//               hand-computed expectations; router placed at (2,2).
// Ports       : none
// Revision    : 1.0 - initial release
// ============================================================================
module tb_router_input_unit;

    localparam logic [1:0] c_BODY   = 2'b00;
    localparam logic [1:0] c_HEAD   = 2'b01;
    localparam logic [1:0] c_TAIL   = 2'b10;
    localparam logic [1:0] c_SINGLE = 2'b11;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] in_flit;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  cur_x;
    logic [3:0]  cur_y;
    logic [4:0]  req;
    logic [4:0]  grant;
    logic [31:0] out_flit;
    logic        out_valid;
    logic [2:0]  out_port;
    logic        err;

    int checks   = 0;
    int failures = 0;

    router_input_unit #(
        .FLIT_SIZE   (32),
        .DEPTH       (4),
        .COORD_WIDTH (4),
        .NUM_PORTS   (5)
    ) u_dut (
        .clk       (clk),
        .rst       (rst),
        .in_flit   (in_flit),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .cur_x     (cur_x),
        .cur_y     (cur_y),
        .req       (req),
        .grant     (grant),
        .out_flit  (out_flit),
        .out_valid (out_valid),
        .out_port  (out_port),
        .err       (err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] mk(input logic [1:0] t, input logic [3:0] x,
                                       input logic [3:0] y, input logic [21:0] p);
        return {t, p, x, y};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_flit(input logic [31:0] f);
        in_flit  = f;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] f;
        logic [31:0] pk [4];

        rst      = 1'b1;
        in_valid = 1'b0;
        in_flit  = '0;
        grant    = '0;
        cur_x    = 4'd2;
        cur_y    = 4'd2;
        repeat (2) @(posedge clk);
        #1;

        // Reset state
        chk("rst_req",       32'(req),       32'h0);
        chk("rst_out_valid", 32'(out_valid), 32'h0);
        chk("rst_err",       32'(err),       32'h0);
        chk("rst_out_port",  32'(out_port),  32'h0);
        chk("rst_in_ready",  32'(in_ready),  32'h1);
        rst = 1'b0;
        tick();

        // Single flit to local port
        f = mk(c_SINGLE, 4'd2, 4'd2, 22'h11);
        in_flit  = f;
        in_valid = 1'b1;
        #1;
        chk("t1_req_push_cycle", 32'(req), 32'h0);
        tick();
        in_valid = 1'b0;
        #1;
        chk("t1_req", 32'(req), 32'h01);
        grant = 5'b00001;
        #1;
        chk("t1_out_valid", 32'(out_valid), 32'h1);
        chk("t1_out_port",  32'(out_port),  32'h0);
        chk("t1_out_flit",  out_flit,       f);
        chk("t1_err",       32'(err),       32'h0);
        tick();
        grant = '0;
        #1;
        chk("t1_req_empty", 32'(req), 32'h0);

        // Westward packet: head/body/tail
        pk[0] = mk(c_HEAD, 4'd1, 4'd3, 22'h21);
        pk[1] = mk(c_BODY, 4'd0, 4'd0, 22'h22);
        pk[2] = mk(c_TAIL, 4'd0, 4'd0, 22'h23);
        for (int i = 0; i < 3; i++) push_flit(pk[i]);
        #1;
        chk("t2_req", 32'(req), 32'h10);
        for (int i = 0; i < 3; i++) begin
            grant = 5'b10000;
            #1;
            chk("t2_req_hold",  32'(req),       32'h10);
            chk("t2_out_valid", 32'(out_valid), 32'h1);
            chk("t2_out_port",  32'(out_port),  32'h4);
            chk("t2_out_flit",  out_flit,       pk[i]);
            tick();
            grant = '0;
        end
        #1;
        chk("t2_req_after_tail", 32'(req), 32'h0);
        f = mk(c_SINGLE, 4'd2, 4'd2, 22'h24);
        push_flit(f);
        #1;
        chk("t2_idle_single_req", 32'(req), 32'h01);
        chk("t2_idle_single_err", 32'(err), 32'h0);
        grant = 5'b00001;
        tick();
        grant = '0;

        // East+South candidates, lock South
        pk[0] = mk(c_HEAD, 4'd3, 4'd0, 22'h31);
        pk[1] = mk(c_BODY, 4'd0, 4'd0, 22'h32);
        pk[2] = mk(c_TAIL, 4'd0, 4'd0, 22'h33);
        for (int i = 0; i < 3; i++) push_flit(pk[i]);
        #1;
        chk("t3_req_head", 32'(req), 32'h0C);
        grant = 5'b01000;
        #1;
        chk("t3_out_port_head", 32'(out_port), 32'h3);
        tick();
        grant = '0;
        #1;
        chk("t3_req_body", 32'(req), 32'h08);
        grant = 5'b01000;
        tick();
        grant = '0;
        #1;
        chk("t3_req_tail", 32'(req), 32'h08);
        grant = 5'b01000;
        #1;
        chk("t3_out_valid_tail", 32'(out_valid), 32'h1);
        chk("t3_out_port_tail",  32'(out_port),  32'h3);
        tick();
        grant = '0;
        #1;
        chk("t3_req_done", 32'(req), 32'h0);

        // Fill to full, blocked push, push+pop at count 3
        pk[0] = mk(c_HEAD, 4'd1, 4'd3, 22'h41);
        push_flit(pk[0]);
        push_flit(mk(c_BODY, 4'd0, 4'd0, 22'h42));
        push_flit(mk(c_BODY, 4'd0, 4'd0, 22'h43));
        push_flit(mk(c_BODY, 4'd0, 4'd0, 22'h44));
        #1;
        chk("t4_full_in_ready", 32'(in_ready), 32'h0);
        in_flit  = mk(c_BODY, 4'd0, 4'd0, 22'hDEAD);
        in_valid = 1'b1;
        grant    = 5'b10000;
        #1;
        chk("t4_full_pop_in_ready", 32'(in_ready),  32'h0);
        chk("t4_full_pop_valid",    32'(out_valid), 32'h1);
        chk("t4_full_pop_flit",     out_flit,       pk[0]);
        tick();
        in_valid = 1'b0;
        grant    = '0;
        #1;
        chk("t4_cnt3_in_ready", 32'(in_ready), 32'h1);
        in_flit  = mk(c_BODY, 4'd0, 4'd0, 22'h45);
        in_valid = 1'b1;
        grant    = 5'b10000;
        #1;
        chk("t4_pushpop_flit", out_flit, mk(c_BODY, 4'd0, 4'd0, 22'h42));
        tick();
        in_valid = 1'b0;
        grant    = '0;
        #1;
        chk("t4_still3_in_ready", 32'(in_ready), 32'h1);
        push_flit(mk(c_BODY, 4'd0, 4'd0, 22'h46));
        #1;
        chk("t4_refull_in_ready", 32'(in_ready), 32'h0);
        pk[0] = mk(c_BODY, 4'd0, 4'd0, 22'h43);
        pk[1] = mk(c_BODY, 4'd0, 4'd0, 22'h44);
        pk[2] = mk(c_BODY, 4'd0, 4'd0, 22'h45);
        pk[3] = mk(c_BODY, 4'd0, 4'd0, 22'h46);
        for (int i = 0; i < 4; i++) begin
            grant = 5'b10000;
            #1;
            chk("t4_drain_flit", out_flit, pk[i]);
            tick();
            grant = '0;
        end
        #1;
        chk("t4_drained_req", 32'(req), 32'h0);
        push_flit(mk(c_TAIL, 4'd0, 4'd0, 22'h47));
        grant = 5'b10000;
        tick();
        grant = '0;

        // Body at head in IDLE is dropped
        push_flit(mk(c_BODY, 4'd0, 4'd0, 22'h51));
        #1;
        chk("t5_drop_err",   32'(err),       32'h1);
        chk("t5_drop_req",   32'(req),       32'h0);
        chk("t5_drop_valid", 32'(out_valid), 32'h0);
        tick();
        #1;
        chk("t5_err_pulse", 32'(err), 32'h0);
        chk("t5_empty_req", 32'(req), 32'h0);

        // Invalid grants are ignored
        f = mk(c_HEAD, 4'd1, 4'd3, 22'h52);
        push_flit(f);
        #1;
        chk("t5_head_req", 32'(req), 32'h10);
        grant = 5'b00011;
        #1;
        chk("t5_multi_err",   32'(err),       32'h1);
        chk("t5_multi_valid", 32'(out_valid), 32'h0);
        tick();
        grant = 5'b00100;
        #1;
        chk("t5_outside_err",   32'(err),       32'h1);
        chk("t5_outside_valid", 32'(out_valid), 32'h0);
        tick();
        grant = '0;
        #1;
        chk("t5_no_pop_req",  32'(req),  32'h10);
        chk("t5_no_pop_flit", out_flit,  f);
        chk("t5_err_clear",   32'(err),  32'h0);
        grant = 5'b10000;
        #1;
        chk("t5_good_grant", 32'(out_valid), 32'h1);
        tick();
        grant = '0;

        // Head arriving while ACTIVE is dropped
        push_flit(mk(c_HEAD, 4'd3, 4'd3, 22'h53));
        #1;
        chk("t5_active_head_err",   32'(err),       32'h1);
        chk("t5_active_head_valid", 32'(out_valid), 32'h0);
        tick();

        // Reset mid-packet with two flits buffered
        push_flit(mk(c_BODY, 4'd0, 4'd0, 22'h61));
        push_flit(mk(c_BODY, 4'd0, 4'd0, 22'h62));
        #1;
        chk("t6_pre_rst_req", 32'(req), 32'h10);
        rst = 1'b1;
        #1;
        chk("t6_rst_req",      32'(req),       32'h0);
        chk("t6_rst_valid",    32'(out_valid), 32'h0);
        chk("t6_rst_in_ready", 32'(in_ready),  32'h1);
        tick();
        tick();
        rst = 1'b0;
        f = mk(c_HEAD, 4'd3, 4'd3, 22'h63);
        push_flit(f);
        #1;
        chk("t6_new_head_req", 32'(req), 32'h06);
        chk("t6_new_head_err", 32'(err), 32'h0);
        grant = 5'b00010;
        #1;
        chk("t6_new_head_port", 32'(out_port), 32'h1);
        chk("t6_new_head_flit", out_flit,      f);
        tick();
        grant = '0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
